uart_boot_loader: RTL

- Host-side initiator of the CPU programming interface; drives the control unit's p_programm/p_address/p_data/p_write_en_mem inputs and watches p_active.
- Receives a framed program image over a UART RX pin.
- Requests programming mode, writes each received nibble into instruction/data memory, then releases the CPU to run from address 0.

---
 rtl/uart_boot_loader_pkg.sv | 24 ++
 rtl/uart_boot_loader_uart_rx.sv | 95 +++++++++
 rtl/uart_boot_loader.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/uart_boot_loader_pkg.sv
// Shared definitions for the UART boot loader: FSM encoding, frame constants
// and the LEN-field decoding rule.
package uart_boot_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN    = 3'd1,
      ST_DATA   = 3'd2,
      ST_CHK    = 3'd3,
      ST_FINISH = 3'd4
   } state_t;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h5A;
   localparam int         LEN_FIELD_W       = 5;
   localparam int         UART_DATA_BITS    = 8;
   localparam logic [LEN_FIELD_W-1:0] MAX_PAYLOAD = 5'd16;

   // A zero LEN field means a full 16-entry image; anything larger is clamped.
   function automatic logic [LEN_FIELD_W-1:0] payload_count(input logic [LEN_FIELD_W-1:0] len_field);
      if (len_field == '0 || len_field > MAX_PAYLOAD) return MAX_PAYLOAD;
      return len_field;
   endfunction

endpackage

// File: rtl/uart_boot_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle
// byte_valid / frame_err strobes.
module uart_boot_loader_uart_rx
   import uart_boot_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk_i,
   input  logic       reset_ni,
   input  logic       rx_i,
   output logic       byte_valid_o,
   output logic       frame_err_o,
   output logic [7:0] byte_o
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT/2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

   rx_state_t        rx_state;
   logic             rx_meta;
   logic             rx_sync;
   logic [CNT_W-1:0] bit_timer;
   logic [2:0]       bit_idx;
   logic [7:0]       shift_q;

   assign byte_o = shift_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         rx_meta      <= 1'b1;
         rx_sync      <= 1'b1;
         rx_state     <= RX_IDLE;
         bit_timer    <= '0;
         bit_idx      <= '0;
         shift_q      <= '0;
         byte_valid_o <= 1'b0;
         frame_err_o  <= 1'b0;
      end else begin
         rx_meta      <= rx_i;
         rx_sync      <= rx_meta;
         byte_valid_o <= 1'b0;
         frame_err_o  <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (!rx_sync) begin
                  bit_timer <= '0;
                  rx_state  <= RX_START;
               end
            end
            RX_START: begin
               if (bit_timer == HALF_M1) begin
                  bit_timer <= '0;
                  bit_idx   <= '0;
                  rx_state  <= rx_sync ? RX_IDLE : RX_DATA;
               end else begin
                  bit_timer <= bit_timer + 1'b1;
               end
            end
            RX_DATA: begin
               if (bit_timer == FULL_M1) begin
                  bit_timer <= '0;
                  shift_q   <= {rx_sync, shift_q[7:1]};
                  bit_idx   <= bit_idx + 3'd1;
                  if (bit_idx == LAST_BIT) rx_state <= RX_STOP;
               end else begin
                  bit_timer <= bit_timer + 1'b1;
               end
            end
            RX_STOP: begin
               if (bit_timer == FULL_M1) begin
                  bit_timer <= '0;
                  if (rx_sync) begin
                     byte_valid_o <= 1'b1;
                     rx_state     <= RX_IDLE;
                  end else begin
                     frame_err_o <= 1'b1;
                     rx_state    <= RX_BREAK;
                  end
               end else begin
                  bit_timer <= bit_timer + 1'b1;
               end
            end
            // A low stop bit must not be mistaken for the next start bit.
            RX_BREAK: if (rx_sync) rx_state <= RX_IDLE;
            default:  rx_state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_boot_loader.sv
// Boot loader: receives a framed image over UART and writes it through the CPU
// programming port. Optional trailing checksum enabled by BOOT_LOADER_CHECKSUM_EN.
module uart_boot_loader
   import uart_boot_loader_pkg::*;
#(
   parameter int         CLKS_PER_BIT         = 434,
   parameter int         REGISTER_WIDTH       = 4,
   parameter int         MEMORY_ADDRESS_WIDTH = 4,
   parameter logic [7:0] SYNC_BYTE            = SYNC_BYTE_DEFAULT
) (
   input  logic                            clk_i,
   input  logic                            reset_ni,
   input  logic                            rx_i,
   input  logic                            p_active_i,
   output logic                            p_programm_o,
   output logic [MEMORY_ADDRESS_WIDTH-1:0] p_address_o,
   output logic [REGISTER_WIDTH-1:0]       p_data_o,
   output logic                            p_write_en_mem_o,
   output logic                            busy_o,
   output logic                            done_strb_o,
   output logic                            err_o
);

   logic       rx_valid;
   logic       rx_frame_err;
   logic [7:0] rx_byte;

   uart_boot_loader_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_rx (
      .clk_i        (clk_i),
      .reset_ni     (reset_ni),
      .rx_i         (rx_i),
      .byte_valid_o (rx_valid),
      .frame_err_o  (rx_frame_err),
      .byte_o       (rx_byte)
   );

   state_t                 state;
   logic [LEN_FIELD_W-1:0] remaining;
   logic                   pend_valid;
   logic [7:0]             pend_byte;
`ifdef BOOT_LOADER_CHECKSUM_EN
   logic [7:0]             chk_xor;
`endif

   logic do_write;
   logic last_write;
   logic accept_byte;
   logic abort;

   // A write frees the buffer in the same cycle, so a byte arriving then is not an overrun.
   assign do_write    = (state == ST_DATA) && pend_valid && p_active_i && !rx_frame_err;
   assign last_write  = do_write && (remaining == LEN_FIELD_W'(1));
   assign accept_byte = (state == ST_DATA) && rx_valid && (!pend_valid || do_write) && !last_write;
   assign abort       = rx_frame_err && (state inside {ST_LEN, ST_DATA, ST_CHK});
   assign busy_o      = (state != ST_IDLE);

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state            <= ST_IDLE;
         remaining        <= '0;
         pend_valid       <= 1'b0;
         pend_byte        <= '0;
         p_programm_o     <= 1'b0;
         p_address_o      <= '0;
         p_data_o         <= '0;
         p_write_en_mem_o <= 1'b0;
         done_strb_o      <= 1'b0;
         err_o            <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
         chk_xor          <= '0;
`endif
      end else begin
         p_write_en_mem_o <= 1'b0;
         done_strb_o      <= 1'b0;
         if (abort) begin
            err_o        <= 1'b1;
            pend_valid   <= 1'b0;
            p_programm_o <= 1'b0;
            state        <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (rx_valid && rx_byte == SYNC_BYTE) begin
                     p_programm_o <= 1'b1;
                     err_o        <= 1'b0;
                     state        <= ST_LEN;
                  end
               end
               ST_LEN: begin
                  if (rx_valid) begin
                     remaining <= payload_count(rx_byte[LEN_FIELD_W-1:0]);
`ifdef BOOT_LOADER_CHECKSUM_EN
                     chk_xor   <= rx_byte;
`endif
                     state     <= ST_DATA;
                  end
               end
               ST_DATA: begin
                  if (do_write) begin
                     p_write_en_mem_o <= 1'b1;
                     p_address_o      <= MEMORY_ADDRESS_WIDTH'(pend_byte[7:4]);
                     p_data_o         <= REGISTER_WIDTH'(pend_byte[3:0]);
                     pend_valid       <= 1'b0;
                     remaining        <= remaining - 1'b1;
`ifdef BOOT_LOADER_CHECKSUM_EN
                     if (last_write) state <= ST_CHK;
`else
                     if (last_write) state <= ST_FINISH;
`endif
                  end
                  if (accept_byte) begin
                     pend_valid <= 1'b1;
                     pend_byte  <= rx_byte;
`ifdef BOOT_LOADER_CHECKSUM_EN
                     chk_xor    <= chk_xor ^ rx_byte;
`endif
                  end else if (rx_valid && !last_write) begin
                     err_o <= 1'b1;
                  end
               end
`ifdef BOOT_LOADER_CHECKSUM_EN
               // On mismatch programming mode is kept so the CPU never runs the bad image.
               ST_CHK: begin
                  if (rx_valid) begin
                     if (rx_byte == chk_xor) begin
                        state <= ST_FINISH;
                     end else begin
                        err_o <= 1'b1;
                        state <= ST_IDLE;
                     end
                  end
               end
`endif
               ST_FINISH: begin
                  p_programm_o <= 1'b0;
                  done_strb_o  <= 1'b1;
                  state        <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
